mem_access_stage: RTL and testbench

//  Memory-access stage between the execute stage and the data memory.

---
 rtl/mem_access_stage_pkg.sv | 13 +
 rtl/mem_access_stage_resp_fifo2.sv | 72 +++++++
 rtl/mem_access_stage.sv | 101 ++++++++++
 tb/tb_mem_access_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the memory-access stage.
//   REQ_LOAD / REQ_STORE : encodings of the request write-enable bit
//   RSP_Q_DEPTH          : number of entries in the load response queue
//   RSP_Q_CNT_W          : width of the queue occupancy counter (holds 0..depth)
package mem_access_stage_pkg;

  localparam logic REQ_LOAD  = 1'b0;
  localparam logic REQ_STORE = 1'b1;

  localparam int RSP_Q_DEPTH = 2;
  localparam int RSP_Q_CNT_W = $clog2(RSP_Q_DEPTH + 1);

endpackage

// File: rtl/mem_access_stage_resp_fifo2.sv
// resp_fifo2: two-entry in-order FIFO holding {tag, data} load responses.
// No pass-through: a pushed entry becomes visible on head the next cycle.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   push, push_data write one entry (ignored while full)
//   pop             retire the head entry (ignored while empty)
//   full, empty     occupancy flags, registered-state only
//   head            oldest entry; zero after reset
module resp_fifo2
  import mem_access_stage_pkg::*;
#(
  parameter int Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  logic [Width-1:0]       ent_q [RSP_Q_DEPTH];
  logic [Width-1:0]       ent_d [RSP_Q_DEPTH];
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic [RSP_Q_CNT_W-1:0] cnt_q, cnt_d;
  logic                   do_push, do_pop;

  assign full  = (cnt_q == RSP_Q_CNT_W'(RSP_Q_DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = ent_q[rd_ptr_q];

  always_comb begin
    ent_d    = ent_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    if (do_push) begin
      ent_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ent_q    <= ent_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: sits between execute and a data memory with combinational
// read and synchronous write. Stores are written at the accepting edge; loads
// capture the memory read data at the accepting edge and return it, tagged,
// through a two-entry response queue. Wrapping load/store counters.
// Ports:
//   CLK, RSTN                       clock, asynchronous active-low reset
//   REQ_VALID/REQ_READY             request handshake
//   REQ_WE/ADD/DATA/TAG             request fields (1 = store)
//   MEM_ADD/MEM_DATAIN/MEM_WEN      memory drive
//   MEM_DATAOUT                     memory read data
//   RSP_VALID/RSP_READY             response handshake
//   RSP_DATA/RSP_TAG                response fields
//   LD_CNT/ST_CNT                   accepted loads/stores since reset
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int AddWidth  = 2,
  parameter int DataWidth = 2,
  parameter int TagWidth  = 2,
  parameter int CntWidth  = 8
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic                 REQ_WE,
  input  logic [AddWidth-1:0]  REQ_ADD,
  input  logic [DataWidth-1:0] REQ_DATA,
  input  logic [TagWidth-1:0]  REQ_TAG,
  output logic [AddWidth-1:0]  MEM_ADD,
  output logic [DataWidth-1:0] MEM_DATAIN,
  output logic                 MEM_WEN,
  input  logic [DataWidth-1:0] MEM_DATAOUT,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [DataWidth-1:0] RSP_DATA,
  output logic [TagWidth-1:0]  RSP_TAG,
  output logic [CntWidth-1:0]  LD_CNT,
  output logic [CntWidth-1:0]  ST_CNT
);

  localparam int EntW = DataWidth + TagWidth;

  logic                acc;
  logic                ld_push;
  logic                rsp_pop;
  logic                q_full;
  logic                q_empty;
  logic [EntW-1:0]     q_head;
  logic [CntWidth-1:0] ld_cnt_q, ld_cnt_d;
  logic [CntWidth-1:0] st_cnt_q, st_cnt_d;

  // Ready depends only on registered occupancy, so a pop in a full cycle
  // frees space from the next cycle onward.
  assign REQ_READY  = ~q_full;
  assign acc        = REQ_VALID & REQ_READY;

  assign MEM_ADD    = REQ_ADD;
  assign MEM_DATAIN = REQ_DATA;
  assign MEM_WEN    = acc & (REQ_WE == REQ_STORE);
  assign ld_push    = acc & (REQ_WE == REQ_LOAD);

  assign RSP_VALID  = ~q_empty;
  assign rsp_pop    = RSP_VALID & RSP_READY;
  assign RSP_DATA   = q_head[DataWidth-1:0];
  assign RSP_TAG    = q_head[EntW-1:DataWidth];

  assign LD_CNT     = ld_cnt_q;
  assign ST_CNT     = st_cnt_q;

  resp_fifo2 #(
    .Width(EntW)
  ) u_rsp_q (
    .clk      (CLK),
    .rst_n    (RSTN),
    .push     (ld_push),
    .push_data({REQ_TAG, MEM_DATAOUT}),
    .pop      (rsp_pop),
    .full     (q_full),
    .empty    (q_empty),
    .head     (q_head)
  );

  always_comb begin
    ld_cnt_d = ld_cnt_q;
    st_cnt_d = st_cnt_q;
    if (ld_push) ld_cnt_d = ld_cnt_q + 1'b1;
    if (MEM_WEN) st_cnt_d = st_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage with a small behavioural data memory
// (combinational read, synchronous write, not reset).
module tb_mem_access_stage;

  localparam int AW = 2;
  localparam int DW = 2;
  localparam int TW = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_add;
  logic [DW-1:0] req_data;
  logic [TW-1:0] req_tag;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_datain, mem_dataout;
  logic          mem_wen;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic [CW-1:0] ld_cnt, st_cnt;

  logic [DW-1:0] dmem [4] = '{2'd0, 2'd0, 2'd0, 2'd0};

  int tests  = 0;
  int failed = 0;

  logic [TW+DW-1:0] exp_q[$];
  logic [TW+DW-1:0] cur_exp;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wen) dmem[mem_add] <= mem_datain;
  assign mem_dataout = dmem[mem_add];

  mem_access_stage #(
    .AddWidth(AW), .DataWidth(DW), .TagWidth(TW), .CntWidth(CW)
  ) dut (
    .CLK(clk), .RSTN(rstn),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
    .REQ_ADD(req_add), .REQ_DATA(req_data), .REQ_TAG(req_tag),
    .MEM_ADD(mem_add), .MEM_DATAIN(mem_datain), .MEM_WEN(mem_wen),
    .MEM_DATAOUT(mem_dataout),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
    .RSP_DATA(rsp_data), .RSP_TAG(rsp_tag),
    .LD_CNT(ld_cnt), .ST_CNT(st_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard push: a load handshake completes at the coming edge.
  always @(negedge clk) begin
    if (rstn && req_valid && req_ready && !req_we) exp_q.push_back(cur_exp);
  end

  // Scoreboard pop: compare the head whenever writeback takes a response.
  always @(negedge clk) begin
    logic [TW+DW-1:0] e;
    if (rstn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_rsp: got data %0d tag %0d, expected no response", rsp_data, rsp_tag);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", int'(rsp_data), int'(e[DW-1:0]));
        check("rsp_tag", int'(rsp_tag), int'(e[TW+DW-1:DW]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [TW-1:0] t, input logic [DW-1:0] exp_d);
    req_valid = 1'b1;
    req_we    = we;
    req_add   = a;
    req_data  = d;
    req_tag   = t;
    cur_exp   = {t, exp_d};
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; rsp_ready = 1'b1; cur_exp = '0;
    req_valid = 1'b0; req_we = 1'b0; req_add = '0; req_data = '0; req_tag = '0;
    @(negedge clk);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_rsp_data", int'(rsp_data), 0);
    check("reset_rsp_tag", int'(rsp_tag), 0);
    check("reset_ld_cnt", int'(ld_cnt), 0);
    check("reset_st_cnt", int'(st_cnt), 0);
    check("reset_req_ready", int'(req_ready), 1);
    tick();
    rstn = 1'b1;
    tick();

    // Store addr 2 data 3, then load addr 2 tag 1 the next cycle.
    drive(1'b1, 2'd2, 2'd3, 2'd0, 2'd0);
    @(negedge clk);
    check("st_mem_wen", int'(mem_wen), 1);
    check("st_mem_add", int'(mem_add), 2);
    check("st_mem_datain", int'(mem_datain), 3);
    tick();
    check("st_cnt_1", int'(st_cnt), 1);
    drive(1'b0, 2'd2, 2'd1, 2'd1, 2'd3);
    @(negedge clk);
    check("ld_mem_wen", int'(mem_wen), 0);
    check("ld_rsp_valid_before", int'(rsp_valid), 0);
    tick();
    idle();
    @(negedge clk);
    check("ld_rsp_valid_after", int'(rsp_valid), 1);
    check("ld_cnt_1", int'(ld_cnt), 1);
    tick();
    @(negedge clk);
    check("rsp_drained", int'(rsp_valid), 0);

    // Memory: addr0=1, addr1=2, addr2=3, addr3=0.
    tick();
    drive(1'b1, 2'd0, 2'd1, 2'd0, 2'd0); tick();
    drive(1'b1, 2'd1, 2'd2, 2'd0, 2'd0); tick();
    idle();
    check("st_cnt_3", int'(st_cnt), 3);

    // Backpressure: three back-to-back loads with writeback stalled.
    rsp_ready = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 2'd0, 2'd1);
    @(negedge clk); check("bp_ready_1", int'(req_ready), 1); tick();
    drive(1'b0, 2'd1, 2'd0, 2'd2, 2'd2);
    @(negedge clk); check("bp_ready_2", int'(req_ready), 1); tick();
    drive(1'b0, 2'd2, 2'd0, 2'd3, 2'd3);
    @(negedge clk);
    check("bp_ready_3", int'(req_ready), 0);
    check("bp_head_data", int'(rsp_data), 1);
    tick();
    @(negedge clk);
    check("bp_hold_data", int'(rsp_data), 1);
    check("bp_hold_tag", int'(rsp_tag), 0);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk); check("bp_full_pop_cycle", int'(req_ready), 0); tick();
    @(negedge clk); check("bp_ready_after", int'(req_ready), 1); tick();
    idle();
    @(negedge clk); check("bp_third_valid", int'(rsp_valid), 1); tick();
    @(negedge clk); check("bp_empty", int'(rsp_valid), 0);
    check("ld_cnt_wrap", int'(ld_cnt), 0);
    tick();

    // Push/pop overlap at occupancy 1.
    rsp_ready = 1'b0;
    drive(1'b0, 2'd3, 2'd0, 2'd1, 2'd0); tick();
    rsp_ready = 1'b1;
    drive(1'b0, 2'd0, 2'd0, 2'd2, 2'd1);
    @(negedge clk); check("ov_ready", int'(req_ready), 1); tick();
    idle();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("ov_valid", int'(rsp_valid), 1);
    check("ov_head_data", int'(rsp_data), 1);
    check("ov_head_tag", int'(rsp_tag), 2);
    check("ov_not_full", int'(req_ready), 1);
    tick();
    rsp_ready = 1'b1;
    tick();
    @(negedge clk); check("ov_occ_was_1", int'(rsp_valid), 0);
    tick();

    // Store blocked while the queue is full.
    rsp_ready = 1'b0;
    drive(1'b0, 2'd1, 2'd0, 2'd0, 2'd2); tick();
    drive(1'b0, 2'd2, 2'd0, 2'd1, 2'd3); tick();
    drive(1'b1, 2'd1, 2'd0, 2'd0, 2'd0);
    @(negedge clk);
    check("blk_ready", int'(req_ready), 0);
    check("blk_mem_wen", int'(mem_wen), 0);
    tick(); tick();
    idle();
    check("blk_mem_unchanged", int'(dmem[1]), 2);
    check("blk_st_cnt", int'(st_cnt), 3);
    rsp_ready = 1'b1;
    tick(); tick();
    @(negedge clk); check("blk_drained", int'(rsp_valid), 0);
    tick();

    // Reset mid-run with a response queued.
    rsp_ready = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 2'd3, 2'd1); tick();
    idle();
    rstn = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_rsp_valid", int'(rsp_valid), 0);
    check("mid_rst_ld_cnt", int'(ld_cnt), 0);
    check("mid_rst_st_cnt", int'(st_cnt), 0);
    check("mid_rst_req_ready", int'(req_ready), 1);
    tick();
    rstn = 1'b1;
    rsp_ready = 1'b1;
    tick();

    // Store counter wrap with a 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      int exp_st;
      exp_st = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 3 : (i == 3) ? 0 : 1;
      drive(1'b1, 2'd3, 2'(i), 2'd0, 2'd0);
      tick();
      check($sformatf("wrap_st_cnt_%0d", i), int'(st_cnt), exp_st);
    end
    idle();
    check("wrap_ld_cnt", int'(ld_cnt), 0);
    tick();

    check("sb_all_rsp_seen", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
